arcade_input_mapper: RTL and testbench

Parametrised player-input front end for arcade cores. It sits between hps_io and the game core. It decodes PS/2 key events into held-key state and merges them with MiSTer joysticks. It applies screen-rotation remapping per player and routes inputs per cabinet mode. It also generates fixed-width coin pulses and optional auto-fire, so each core top level no longer carries its own key decoder.

---
 rtl/arcade_input_mapper.sv | 223 ++++++++++++++++++++++
 tb/tb_arcade_input_mapper.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_mapper.sv
// Player-input front end: PS/2 key decode, pad merge, rotation,
// cabinet routing, coin pulse shaping and auto-fire.
module arcade_input_mapper #(
    parameter int          PLAYERS      = 2,
    parameter logic [15:0] COIN_PULSE   = 16'd6000,
    parameter logic [19:0] AUTOFIRE_DIV = 20'd200000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic [1:0]  rotate,
    input  logic        cocktail,
    input  logic        autofire_en,
    output logic [3:0]  p1_dir,
    output logic        p1_fire,
    output logic [3:0]  p2_dir,
    output logic        p2_fire,
    output logic        start1,
    output logic        start2,
    output logic        coin1,
    output logic        coin2
);

    logic       tog_q;
    logic       primed;
    logic       ps2_evt;
    logic       pressed;
    logic [8:0] code;
    logic [7:0] lo;

    logic [3:0] k1_dir;
    logic [3:0] k2_dir;
    logic       k1_fire;
    logic       k2_fire;
    logic       k_start1;
    logic       k_start2;
    logic       k_coin1;
    logic       k_coin2;

    logic m_up, m_dn, m_lf, m_rt, m_fire;
    logic m_s1, m_s2, m_c1, m_c2;
    logic m2_up, m2_dn, m2_lf, m2_rt, m2_fire;

    assign pressed = ps2_key[9];
    assign code    = ps2_key[8:0];
    assign lo      = ps2_key[7:0];
    // The first cycle after reset only captures the toggle bit.
    assign ps2_evt = primed && (ps2_key[10] != tog_q);

    assign m_up    = (lo == 8'h75);
    assign m_dn    = (lo == 8'h72);
    assign m_lf    = (lo == 8'h6B);
    assign m_rt    = (lo == 8'h74);
    assign m_fire  = (code == 9'h029) || (code == 9'h014);
    assign m_s1    = (code == 9'h005) || (code == 9'h016);
    assign m_s2    = (code == 9'h006) || (code == 9'h01E);
    assign m_c1    = (code == 9'h02E);
    assign m_c2    = (code == 9'h036);
    assign m2_up   = (code == 9'h02D);
    assign m2_dn   = (code == 9'h02B);
    assign m2_lf   = (code == 9'h023);
    assign m2_rt   = (code == 9'h034);
    assign m2_fire = (code == 9'h01C);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q    <= 1'b0;
            primed   <= 1'b0;
            k1_dir   <= 4'b0;
            k2_dir   <= 4'b0;
            k1_fire  <= 1'b0;
            k2_fire  <= 1'b0;
            k_start1 <= 1'b0;
            k_start2 <= 1'b0;
            k_coin1  <= 1'b0;
            k_coin2  <= 1'b0;
        end else begin
            tog_q  <= ps2_key[10];
            primed <= 1'b1;
            if (ps2_evt) begin
                unique case (1'b1)
                    m_up:    k1_dir[3] <= pressed;
                    m_dn:    k1_dir[2] <= pressed;
                    m_lf:    k1_dir[1] <= pressed;
                    m_rt:    k1_dir[0] <= pressed;
                    m_fire:  k1_fire   <= pressed;
                    m_s1:    k_start1  <= pressed;
                    m_s2:    k_start2  <= pressed;
                    m_c1:    k_coin1   <= pressed;
                    m_c2:    k_coin2   <= pressed;
                    m2_up:   k2_dir[3] <= pressed;
                    m2_dn:   k2_dir[2] <= pressed;
                    m2_lf:   k2_dir[1] <= pressed;
                    m2_rt:   k2_dir[0] <= pressed;
                    m2_fire: k2_fire   <= pressed;
                    default: ;
                endcase
            end
        end
    end

    logic [4:0] pad1;
    logic [4:0] pad2;
    logic [3:0] raw1;
    logic [3:0] raw2;
    logic [1:0] fire_m;
    logic [1:0] creq;
    logic       unused_bits;

    assign pad1 = cocktail ? joystick_0[4:0]
                           : (joystick_0[4:0] | joystick_1[4:0]);
    assign pad2 = cocktail ? joystick_1[4:0]
                           : (joystick_0[4:0] | joystick_1[4:0]);
    assign raw1 = k1_dir | pad1[3:0];
    assign raw2 = k2_dir | pad2[3:0];
    assign fire_m[0] = k1_fire | pad1[4];
    assign fire_m[1] = k2_fire | pad2[4];
    assign creq[0] = k_coin1 | joystick_0[7];
    assign creq[1] = k_coin2 | joystick_1[7];

    assign unused_bits = ^{joystick_0[15:8], joystick_1[15:8],
                           joystick_1[6]};

    // Direction vectors are {up, down, left, right}.
    function automatic logic [3:0] rot(input logic [3:0] d,
                                       input logic [1:0] r);
        logic [3:0] o;
        case (r)
            2'd1:    o = {d[1], d[0], d[2], d[3]};
            2'd2:    o = {d[0], d[1], d[3], d[2]};
            default: o = d;
        endcase
        return o;
    endfunction

    logic [1:0]  creq_q;
    logic [1:0]  coin_q;
    logic [15:0] ccnt [2];

    // A slot is idle only once its output has actually dropped.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            creq_q <= 2'b0;
            coin_q <= 2'b0;
            for (int i = 0; i < 2; i++) ccnt[i] <= 16'd0;
        end else begin
            creq_q <= creq;
            for (int i = 0; i < 2; i++) begin
                if (coin_q[i]) begin
                    if (ccnt[i] == 16'd0) coin_q[i] <= 1'b0;
                    else ccnt[i] <= ccnt[i] - 16'd1;
                end else if (primed && creq[i] && !creq_q[i]) begin
                    coin_q[i] <= 1'b1;
                    ccnt[i]   <= COIN_PULSE - 16'd1;
                end
            end
        end
    end

    assign coin1 = coin_q[0];
    assign coin2 = coin_q[1];

    logic [1:0]  fire_q;
    logic [1:0]  phase;
    logic [1:0]  phase_nxt;
    logic [19:0] afcnt [2];
    logic [19:0] afcnt_nxt [2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            phase_nxt[i] = phase[i];
            afcnt_nxt[i] = afcnt[i];
            if (!fire_m[i]) begin
                phase_nxt[i] = 1'b0;
                afcnt_nxt[i] = 20'd0;
            end else if (!fire_q[i]) begin
                phase_nxt[i] = 1'b1;
                afcnt_nxt[i] = 20'd0;
            end else if (afcnt[i] == AUTOFIRE_DIV - 20'd1) begin
                phase_nxt[i] = ~phase[i];
                afcnt_nxt[i] = 20'd0;
            end else begin
                afcnt_nxt[i] = afcnt[i] + 20'd1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            fire_q <= 2'b0;
            phase  <= 2'b0;
            for (int i = 0; i < 2; i++) afcnt[i] <= 20'd0;
        end else begin
            fire_q <= fire_m;
            phase  <= phase_nxt;
            for (int i = 0; i < 2; i++) afcnt[i] <= afcnt_nxt[i];
        end
    end

    logic [1:0] fire_sel;
    assign fire_sel = autofire_en ? phase_nxt : fire_m;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            p1_dir  <= 4'b0;
            p1_fire <= 1'b0;
            p2_dir  <= 4'b0;
            p2_fire <= 1'b0;
            start1  <= 1'b0;
            start2  <= 1'b0;
        end else begin
            p1_dir  <= rot(raw1, rotate);
            p1_fire <= fire_sel[0];
            p2_dir  <= (PLAYERS > 1) ? rot(raw2, rotate) : 4'b0;
            p2_fire <= (PLAYERS > 1) ? fire_sel[1] : 1'b0;
            start1  <= k_start1 | joystick_0[5];
            start2  <= k_start2 | joystick_0[6] | joystick_1[5];
        end
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Scoreboard bench: a cycle-level reference model predicts every
// output; a monitor compares two DUT instances (2 and 1 players).
module tb_arcade_input_mapper;

    localparam int DIV = 3;
    localparam int PULSE = 4;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] ps2_key = '0;
    logic [15:0] joystick_0 = '0;
    logic [15:0] joystick_1 = '0;
    logic [1:0]  rotate = '0;
    logic        cocktail = 1'b0;
    logic        autofire_en = 1'b0;

    logic [3:0] a_p1d, a_p2d, b_p1d, b_p2d;
    logic a_p1f, a_p2f, a_s1, a_s2, a_c1, a_c2;
    logic b_p1f, b_p2f, b_s1, b_s2, b_c1, b_c2;

    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper #(
        .PLAYERS(2), .COIN_PULSE(16'(PULSE)),
        .AUTOFIRE_DIV(20'(DIV))
    ) u_a (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
        .joystick_0(joystick_0), .joystick_1(joystick_1),
        .rotate(rotate), .cocktail(cocktail),
        .autofire_en(autofire_en),
        .p1_dir(a_p1d), .p1_fire(a_p1f),
        .p2_dir(a_p2d), .p2_fire(a_p2f),
        .start1(a_s1), .start2(a_s2), .coin1(a_c1), .coin2(a_c2)
    );

    arcade_input_mapper #(
        .PLAYERS(1), .COIN_PULSE(16'(PULSE)),
        .AUTOFIRE_DIV(20'(DIV))
    ) u_b (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
        .joystick_0(joystick_0), .joystick_1(joystick_1),
        .rotate(rotate), .cocktail(cocktail),
        .autofire_en(autofire_en),
        .p1_dir(b_p1d), .p1_fire(b_p1f),
        .p2_dir(b_p2d), .p2_fire(b_p2f),
        .start1(b_s1), .start2(b_s2), .coin1(b_c1), .coin2(b_c2)
    );

    typedef struct packed {
        logic [3:0] p1d;
        logic       p1f;
        logic [3:0] p2d;
        logic       p2f;
        logic       s1;
        logic       s2;
        logic       c1;
        logic       c2;
    } out_t;

    out_t sb[$];
    int total = 0;
    int bad = 0;

    // Reference model state.
    bit held[14];
    int hold_c[2];
    int rem[2];
    bit prev_req[2];
    bit prev_out[2];
    bit prev_tog;
    bit first;
    int keymap[int];

    task automatic chk(input string nm, input logic [3:0] act,
                       input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // up<=left etc, expressed on named directions
    function automatic logic [3:0] rot_m(input logic [3:0] d,
                                         input logic [1:0] r);
        logic up, dn, lf, rt;
        up = d[3]; dn = d[2]; lf = d[1]; rt = d[0];
        if (r == 2'd1) return {lf, rt, dn, up};
        if (r == 2'd2) return {rt, lf, up, dn};
        return {up, dn, lf, rt};
    endfunction

    task automatic step();
        out_t e;
        logic [4:0] pa, pb;
        logic [3:0] k1, k2;
        logic m[2];
        logic req[2];
        logic f[2];
        logic ph;
        logic rise;
        e = '0;
        if (!reset_n) begin
            foreach (held[i]) held[i] = 1'b0;
            for (int i = 0; i < 2; i++) begin
                hold_c[i] = 0; rem[i] = 0;
                prev_req[i] = 0; prev_out[i] = 0;
            end
            prev_tog = 1'b0;
            first = 1'b1;
        end else begin
            pa = cocktail ? joystick_0[4:0]
                          : joystick_0[4:0] | joystick_1[4:0];
            pb = cocktail ? joystick_1[4:0]
                          : joystick_0[4:0] | joystick_1[4:0];
            k1 = {held[0], held[1], held[2], held[3]};
            k2 = {held[9], held[10], held[11], held[12]};
            e.p1d = rot_m(k1 | pa[3:0], rotate);
            e.p2d = rot_m(k2 | pb[3:0], rotate);
            m[0] = held[4] | pa[4];
            m[1] = held[13] | pb[4];
            for (int i = 0; i < 2; i++) begin
                hold_c[i] = m[i] ? hold_c[i] + 1 : 0;
                ph = m[i] && (((hold_c[i] - 1) / DIV) % 2 == 0);
                f[i] = autofire_en ? ph : m[i];
            end
            e.p1f = f[0];
            e.p2f = f[1];
            e.s1 = held[5] | joystick_0[5];
            e.s2 = held[6] | joystick_0[6] | joystick_1[5];
            req[0] = held[7] | joystick_0[7];
            req[1] = held[8] | joystick_1[7];
            for (int i = 0; i < 2; i++) begin
                rise = !first && req[i] && !prev_req[i];
                if (rem[i] > 0) begin
                    rem[i]--;
                    prev_out[i] = 1'b1;
                end else if (rise && !prev_out[i]) begin
                    rem[i] = PULSE - 1;
                    prev_out[i] = 1'b1;
                end else begin
                    prev_out[i] = 1'b0;
                end
                prev_req[i] = req[i];
            end
            e.c1 = prev_out[0];
            e.c2 = prev_out[1];
            if (!first && ps2_key[10] != prev_tog &&
                keymap.exists(int'(ps2_key[8:0])))
                held[keymap[int'(ps2_key[8:0])]] = ps2_key[9];
            prev_tog = ps2_key[10];
            first = 1'b0;
        end
        sb.push_back(e);
        @(negedge clk_sys);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic key(input logic pr, input logic [8:0] c);
        ps2_key = {~ps2_key[10], pr, c};
    endtask

    initial begin : monitor
        out_t e;
        forever begin
            @(posedge clk_sys);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("p1_dir", a_p1d, e.p1d);
                chk("p1_fire", {3'b0, a_p1f}, {3'b0, e.p1f});
                chk("p2_dir", a_p2d, e.p2d);
                chk("p2_fire", {3'b0, a_p2f}, {3'b0, e.p2f});
                chk("start", {2'b0, a_s1, a_s2}, {2'b0, e.s1, e.s2});
                chk("coin", {2'b0, a_c1, a_c2}, {2'b0, e.c1, e.c2});
                chk("p1only_p1", {b_p1d}, e.p1d);
                chk("p1only_p2", {b_p2d[3:1], b_p2d[0] | b_p2f},
                    4'b0);
                chk("p1only_misc", {b_p1f, b_s1, b_c1, b_c2},
                    {e.p1f, e.s1, e.c1, e.c2});
            end
        end
    end

    int codes[$];

    initial begin : driver
        for (int x = 0; x < 512; x += 256) begin
            keymap[x | 'h75] = 0; keymap[x | 'h72] = 1;
            keymap[x | 'h6B] = 2; keymap[x | 'h74] = 3;
        end
        keymap['h029] = 4;  keymap['h014] = 4;
        keymap['h005] = 5;  keymap['h016] = 5;
        keymap['h006] = 6;  keymap['h01E] = 6;
        keymap['h02E] = 7;  keymap['h036] = 8;
        keymap['h02D] = 9;  keymap['h02B] = 10;
        keymap['h023] = 11; keymap['h034] = 12;
        keymap['h01C] = 13;
        foreach (keymap[k]) codes.push_back(k);
        codes.push_back('h114);
        codes.push_back('h0AA);
        codes.push_back('h12E);

        @(negedge clk_sys);
        ps2_key = 11'h400;
        run(3);
        reset_n = 1'b1;
        run(3);
        key(1'b1, 9'h029);
        run(4);
        key(1'b0, 9'h029);
        run(4);

        joystick_0 = 16'h0002;
        rotate = 2'd1; run(3);
        rotate = 2'd2; run(3);
        rotate = 2'd3; run(3);
        rotate = 2'd0; joystick_0 = 16'h0; run(2);

        joystick_0 = 16'h0080; run(20);
        joystick_0 = 16'h0; run(3);
        joystick_0 = 16'h0080; run(1);
        joystick_0 = 16'h0; run(1);
        joystick_0 = 16'h0080; run(5);
        joystick_0 = 16'h0; run(8);

        autofire_en = 1'b1;
        joystick_0 = 16'h0010; run(12);
        joystick_0 = 16'h0; run(3);
        autofire_en = 1'b0;

        cocktail = 1'b1; joystick_1 = 16'h0008; run(3);
        cocktail = 1'b0; run(3);
        joystick_1 = 16'h0;

        key(1'b1, 9'h01C); run(4);
        key(1'b0, 9'h01C); run(2);

        joystick_0 = 16'h0080; run(2);
        reset_n = 1'b0;
        #1;
        chk("coin_async_a", {3'b0, a_c1}, 4'b0);
        chk("coin_async_b", {3'b0, b_c1}, 4'b0);
        run(2);
        reset_n = 1'b1; run(10);
        joystick_0 = 16'h0; run(2);

        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 5) == 0)
                key(1'($urandom_range(0, 1)),
                    9'(codes[$urandom_range(0, codes.size() - 1)]));
            if ($urandom_range(0, 7) == 0)
                joystick_0 = 16'($urandom);
            if ($urandom_range(0, 7) == 0)
                joystick_1 = 16'($urandom);
            if ($urandom_range(0, 39) == 0)
                rotate = 2'($urandom);
            if ($urandom_range(0, 39) == 0)
                cocktail = ~cocktail;
            if ($urandom_range(0, 29) == 0)
                autofire_en = ~autofire_en;
            reset_n = ($urandom_range(0, 499) != 0);
            step();
        end
        reset_n = 1'b1;
        run(2);

        repeat (3) @(posedge clk_sys);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
